// File: rtl/parking_lot_pkg.sv
// Shared types, constants and helpers for the parking-lot elevator controller.
// Slot words pack two plates per floor: [31:16] SUV (place 0), [15:0] sedan (place 1).
package parking_lot_pkg;

    localparam int         NUM_FLOORS = 7;
    localparam logic       SLOT_SUV   = 1'b0;
    localparam logic       SLOT_SEDAN = 1'b1;
    localparam logic [7:0] FEE_SAT    = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FETCH = 3'b001,
        ST_LOAD  = 3'b010,
        ST_CARRY = 3'b011,
        ST_DROP  = 3'b100
    } state_e;

    // A BCD digit is odd exactly when its LSB is set.
    function automatic logic plate_place(input logic [15:0] plate);
        return plate[0] ? SLOT_SUV : SLOT_SEDAN;
    endfunction

    function automatic logic [15:0] slot_field(input logic [31:0] word, input logic place);
        return (place == SLOT_SUV) ? word[31:16] : word[15:0];
    endfunction

    function automatic logic [31:0] slot_set(input logic [31:0] word, input logic place,
                                             input logic [15:0] val);
        logic [31:0] w;
        w = word;
        if (place == SLOT_SUV) w[31:16] = val;
        else                   w[15:0]  = val;
        return w;
    endfunction

    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] goal);
        if (goal > cur)      return cur + 3'd1;
        else if (goal < cur) return cur - 3'd1;
        else                 return cur;
    endfunction

    // SUVs pay double, clipped to the 8-bit fee range.
    function automatic logic [7:0] calc_fee(input logic [7:0] cnt, input logic place);
        logic [8:0] dbl;
        dbl = {cnt, 1'b0};
        if (place == SLOT_SEDAN) return cnt;
        return dbl[8] ? FEE_SAT : dbl[7:0];
    endfunction

endpackage

// File: rtl/parking_lot_slot_search.sv
// Combinational slot lookup: lowest usable free slot of a given place, and where a plate is parked.
// Zero latency; plate 0 never matches since it marks an empty slot.
module parking_slot_search
    import parking_lot_pkg::*;
(
    input  logic [NUM_FLOORS-1:0][31:0] slots_i,
    input  logic [NUM_FLOORS-1:0]       flood_i,
    input  logic [15:0]                 plate_i,
    input  logic                        place_i,
    output logic                        free_found_o,
    output logic [2:0]                  free_floor_o,
    output logic                        hit_found_o,
    output logic [2:0]                  hit_floor_o,
    output logic                        hit_place_o
);

    always_comb begin
        free_found_o = 1'b0;
        free_floor_o = 3'd0;
        hit_found_o  = 1'b0;
        hit_floor_o  = 3'd0;
        hit_place_o  = SLOT_SUV;
        // Walk top-down so the lowest qualifying floor is the last one written.
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (!flood_i[f] && (slot_field(slots_i[f], place_i) == 16'h0)) begin
                free_found_o = 1'b1;
                free_floor_o = 3'(f + 1);
            end
            if (plate_i != 16'h0) begin
                if (slot_field(slots_i[f], SLOT_SUV) == plate_i) begin
                    hit_found_o = 1'b1;
                    hit_floor_o = 3'(f + 1);
                    hit_place_o = SLOT_SUV;
                end
                if (slot_field(slots_i[f], SLOT_SEDAN) == plate_i) begin
                    hit_found_o = 1'b1;
                    hit_floor_o = 3'(f + 1);
                    hit_place_o = SLOT_SEDAN;
                end
            end
        end
    end

endmodule

// File: rtl/parking_lot_top.sv
// Automated parking lot: one elevator shuttles cars between ground floor 0 and slots on floors 1..7.
// A transaction takes |floor-pickup|+|pickup-dest|+2 cycles after capture; requests arriving while busy are dropped.
module parking_lot_top
    import parking_lot_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] license_plate,
    input  logic        in_mode,
    input  logic        out_mode,
    input  logic        leakage,
    input  logic [2:0]  leakage_floor,
    output logic [31:0] parked_1,
    output logic [31:0] parked_2,
    output logic [31:0] parked_3,
    output logic [31:0] parked_4,
    output logic [31:0] parked_5,
    output logic [31:0] parked_6,
    output logic [31:0] parked_7,
    output logic [2:0]  current_floor,
    output logic [15:0] moving,
    output logic        plate_type,
    output logic [7:0]  fee,
    output logic [3:0]  empty_suv,
    output logic [3:0]  empty_sedan,
    output logic        full_suv,
    output logic        full_sedan,
    output logic        in_mode_internal,
    output logic        out_mode_internal,
    output logic [15:0] license_plate_internal,
    output logic [2:0]  curr_state_for_test,
    output logic [2:0]  target_floor,
    output logic        target_place
);

    state_e                          state_q, state_d;
    logic [2:0]                      floor_q, floor_d;
    logic [15:0]                     moving_q, moving_d;
    logic [7:0]                      fee_q, fee_d;
    logic [15:0]                     plate_q, plate_d;
    logic                            in_q, in_d;
    logic                            out_q, out_d;
    logic [2:0]                      tgt_floor_q, tgt_floor_d;
    logic                            tgt_place_q, tgt_place_d;
    logic [NUM_FLOORS-1:0][31:0]     slot_q, slot_d;
    logic [NUM_FLOORS-1:0][1:0][7:0] cnt_q, cnt_d;
    logic [NUM_FLOORS-1:0]           flood_q, flood_d;

    logic       free_found, hit_found, hit_place;
    logic [2:0] free_floor, hit_floor;
    logic [2:0] pickup, dest, tgt_idx, next_floor;
    logic [3:0] empty_suv_c, empty_sedan_c;

    // Searches only matter in IDLE, so they key on the live request plate.
    parking_slot_search u_search (
        .slots_i      (slot_q),
        .flood_i      (flood_q),
        .plate_i      (license_plate),
        .place_i      (plate_place(license_plate)),
        .free_found_o (free_found),
        .free_floor_o (free_floor),
        .hit_found_o  (hit_found),
        .hit_floor_o  (hit_floor),
        .hit_place_o  (hit_place)
    );

    assign pickup  = in_q ? 3'd0 : tgt_floor_q;
    assign dest    = in_q ? tgt_floor_q : 3'd0;
    assign tgt_idx = tgt_floor_q - 3'd1;

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        moving_d    = moving_q;
        fee_d       = fee_q;
        plate_d     = plate_q;
        in_d        = in_q;
        out_d       = out_q;
        tgt_floor_d = tgt_floor_q;
        tgt_place_d = tgt_place_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        flood_d     = flood_q;
        next_floor  = 3'd0;

        if (leakage && (leakage_floor != 3'd0)) begin
            flood_d[leakage_floor - 3'd1] = 1'b1;
        end

        for (int f = 0; f < NUM_FLOORS; f++) begin
            for (int p = 0; p < 2; p++) begin
                if ((slot_field(slot_q[f], p == 1) != 16'h0) && (cnt_q[f][p] != FEE_SAT)) begin
                    cnt_d[f][p] = cnt_q[f][p] + 8'd1;
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (in_mode || out_mode) begin
                    plate_d = license_plate;
                    in_d    = in_mode;
                    out_d   = !in_mode;
                    if (in_mode) begin
                        if (free_found && !hit_found && (license_plate != 16'h0)) begin
                            tgt_floor_d = free_floor;
                            tgt_place_d = plate_place(license_plate);
                            state_d     = (floor_q == 3'd0) ? ST_LOAD : ST_FETCH;
                        end
                    end else if (hit_found) begin
                        tgt_floor_d = hit_floor;
                        tgt_place_d = hit_place;
                        state_d     = (floor_q == hit_floor) ? ST_LOAD : ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (floor_q == pickup) begin
                    state_d = ST_LOAD;
                end else begin
                    next_floor = step_toward(floor_q, pickup);
                    floor_d    = next_floor;
                    if (next_floor == pickup) state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                moving_d = plate_q;
                if (out_q) begin
                    slot_d[tgt_idx] = slot_set(slot_q[tgt_idx], tgt_place_q, 16'h0);
                    fee_d           = calc_fee(cnt_q[tgt_idx][tgt_place_q], tgt_place_q);
                end else begin
                    fee_d = 8'd0;
                end
                state_d = ST_CARRY;
            end
            ST_CARRY: begin
                if (floor_q == dest) begin
                    state_d = ST_DROP;
                end else begin
                    next_floor = step_toward(floor_q, dest);
                    floor_d    = next_floor;
                    if (next_floor == dest) state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (in_q) begin
                    slot_d[tgt_idx]             = slot_set(slot_q[tgt_idx], tgt_place_q, plate_q);
                    cnt_d[tgt_idx][tgt_place_q] = 8'd0;
                end
                moving_d = 16'h0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            floor_q     <= 3'd0;
            moving_q    <= 16'h0;
            fee_q       <= 8'd0;
            plate_q     <= 16'h0;
            in_q        <= 1'b0;
            out_q       <= 1'b0;
            tgt_floor_q <= 3'd0;
            tgt_place_q <= SLOT_SUV;
            slot_q      <= '0;
            cnt_q       <= '0;
            flood_q     <= '0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            moving_q    <= moving_d;
            fee_q       <= fee_d;
            plate_q     <= plate_d;
            in_q        <= in_d;
            out_q       <= out_d;
            tgt_floor_q <= tgt_floor_d;
            tgt_place_q <= tgt_place_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            flood_q     <= flood_d;
        end
    end

    // Flooded floors contribute nothing to the free counts even if slots are empty.
    always_comb begin
        empty_suv_c   = 4'd0;
        empty_sedan_c = 4'd0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (!flood_q[f]) begin
                if (slot_field(slot_q[f], SLOT_SUV) == 16'h0)   empty_suv_c   = empty_suv_c + 4'd1;
                if (slot_field(slot_q[f], SLOT_SEDAN) == 16'h0) empty_sedan_c = empty_sedan_c + 4'd1;
            end
        end
    end

    assign parked_1               = slot_q[0];
    assign parked_2               = slot_q[1];
    assign parked_3               = slot_q[2];
    assign parked_4               = slot_q[3];
    assign parked_5               = slot_q[4];
    assign parked_6               = slot_q[5];
    assign parked_7               = slot_q[6];
    assign current_floor          = floor_q;
    assign moving                 = moving_q;
    assign plate_type             = plate_q[0];
    assign fee                    = fee_q;
    assign empty_suv              = empty_suv_c;
    assign empty_sedan            = empty_sedan_c;
    assign full_suv               = (empty_suv_c == 4'd0);
    assign full_sedan             = (empty_sedan_c == 4'd0);
    assign in_mode_internal       = in_q;
    assign out_mode_internal      = out_q;
    assign license_plate_internal = plate_q;
    assign curr_state_for_test    = state_q;
    assign target_floor           = tgt_floor_q;
    assign target_place           = tgt_place_q;

endmodule

// File: tb/tb_parking_lot_top.sv
// Directed and randomized bench for parking_lot_top with a slot/timeline reference model.
module tb_parking_lot_top;

    logic        clock;
    logic        reset;
    logic [15:0] license_plate;
    logic        in_mode, out_mode, leakage;
    logic [2:0]  leakage_floor;
    logic [31:0] parked_1, parked_2, parked_3, parked_4, parked_5, parked_6, parked_7;
    logic [2:0]  current_floor;
    logic [15:0] moving;
    logic        plate_type;
    logic [7:0]  fee;
    logic [3:0]  empty_suv, empty_sedan;
    logic        full_suv, full_sedan;
    logic        in_mode_internal, out_mode_internal;
    logic [15:0] license_plate_internal;
    logic [2:0]  curr_state_for_test, target_floor;
    logic        target_place;

    parking_lot_top dut (
        .clock(clock), .reset(reset), .license_plate(license_plate),
        .in_mode(in_mode), .out_mode(out_mode), .leakage(leakage), .leakage_floor(leakage_floor),
        .parked_1(parked_1), .parked_2(parked_2), .parked_3(parked_3), .parked_4(parked_4),
        .parked_5(parked_5), .parked_6(parked_6), .parked_7(parked_7),
        .current_floor(current_floor), .moving(moving), .plate_type(plate_type), .fee(fee),
        .empty_suv(empty_suv), .empty_sedan(empty_sedan), .full_suv(full_suv), .full_sedan(full_sedan),
        .in_mode_internal(in_mode_internal), .out_mode_internal(out_mode_internal),
        .license_plate_internal(license_plate_internal), .curr_state_for_test(curr_state_for_test),
        .target_floor(target_floor), .target_place(target_place)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] parked [1:7];
    assign parked[1] = parked_1;
    assign parked[2] = parked_2;
    assign parked[3] = parked_3;
    assign parked[4] = parked_4;
    assign parked[5] = parked_5;
    assign parked[6] = parked_6;
    assign parked[7] = parked_7;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference model: slot contents, time each car was parked, flood flags, elevator floor, last fee.
    logic [15:0] m_slot  [1:7][0:1];
    int          m_park  [1:7][0:1];
    bit          m_flood [1:7];
    int          m_floor;
    int          m_fee;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic model_reset();
        for (int f = 1; f <= 7; f++) begin
            m_flood[f] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_slot[f][p] = 16'h0;
                m_park[f][p] = 0;
            end
        end
        m_floor = 0;
        m_fee   = 0;
    endtask

    function automatic int m_empty(input int p);
        int n;
        n = 0;
        for (int f = 1; f <= 7; f++) if (!m_flood[f] && m_slot[f][p] == 16'h0) n++;
        return n;
    endfunction

    function automatic bit m_find(input logic [15:0] plate, output int ff, output int pp);
        ff = 0;
        pp = 0;
        if (plate == 16'h0) return 1'b0;
        for (int f = 1; f <= 7; f++)
            for (int p = 0; p < 2; p++)
                if (m_slot[f][p] == plate) begin
                    ff = f;
                    pp = p;
                    return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic logic [15:0] rand_plate(input bit suv);
        logic [15:0] pl;
        pl[15:12] = 4'($urandom_range(0, 9));
        pl[11:8]  = 4'($urandom_range(0, 9));
        pl[7:4]   = 4'($urandom_range(0, 9));
        pl[3:0]   = 4'(2 * $urandom_range(0, 4) + (suv ? 1 : 0));
        if (pl == 16'h0) pl[15:12] = 4'd1;
        return pl;
    endfunction

    task automatic chk_all(input string ctx);
        for (int f = 1; f <= 7; f++)
            chk($sformatf("%s parked_%0d", ctx, f), parked[f], {m_slot[f][0], m_slot[f][1]});
        chk({ctx, " empty_suv"}, 32'(empty_suv), 32'(m_empty(0)));
        chk({ctx, " empty_sedan"}, 32'(empty_sedan), 32'(m_empty(1)));
        chk({ctx, " full_suv"}, 32'(full_suv), 32'(m_empty(0) == 0));
        chk({ctx, " full_sedan"}, 32'(full_sedan), 32'(m_empty(1) == 0));
        chk({ctx, " current_floor"}, 32'(current_floor), 32'(m_floor));
        chk({ctx, " moving"}, 32'(moving), 32'h0);
        chk({ctx, " fee"}, 32'(fee), 32'(m_fee));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic leak(input int fl);
        leakage       = 1'b1;
        leakage_floor = 3'(fl);
        tick();
        leakage       = 1'b0;
        leakage_floor = 3'd0;
        if (fl != 0) m_flood[fl] = 1'b1;
        chk_all($sformatf("leak%0d", fl));
    endtask

    // Issue one request from IDLE and follow it to completion; poke drives a stray
    // in_mode pulse during the carry phase, which the DUT must drop.
    task automatic do_request(input bit entry, input logic [15:0] plate, input bit poke);
        int  tf, tp, pf, pp, pick, dst, cnt, efee;
        bit  ok, first;
        ok = 1'b0;
        tf = 0;
        tp = 0;
        if (entry) begin
            tp = plate[0] ? 0 : 1;
            if (plate != 16'h0 && !m_find(plate, pf, pp))
                for (int f = 1; f <= 7; f++)
                    if (!ok && !m_flood[f] && m_slot[f][tp] == 16'h0) begin
                        ok = 1'b1;
                        tf = f;
                    end
        end else begin
            ok = m_find(plate, tf, tp);
        end
        license_plate = plate;
        in_mode       = entry;
        out_mode      = !entry;
        tick();
        in_mode  = 1'b0;
        out_mode = 1'b0;
        chk("plate_internal", 32'(license_plate_internal), 32'(plate));
        chk("plate_type", 32'(plate_type), 32'(plate[0]));
        chk("in_internal", 32'(in_mode_internal), 32'(entry));
        if (!ok) begin
            chk("ignored_state", 32'(curr_state_for_test), 32'd0);
            chk_all("ignored");
            return;
        end
        pick = entry ? 0 : tf;
        dst  = entry ? tf : 0;
        chk("target_floor", 32'(target_floor), 32'(tf));
        chk("target_place", 32'(target_place), 32'(tp));
        chk("state_capture", 32'(curr_state_for_test), (m_floor == pick) ? 32'd2 : 32'd1);
        while (m_floor != pick) begin
            tick();
            m_floor += (pick > m_floor) ? 1 : -1;
            chk("fetch_floor", 32'(current_floor), 32'(m_floor));
        end
        tick();
        if (!entry) begin
            cnt = edge_n - m_park[tf][tp] - 1;
            if (cnt > 255) cnt = 255;
            efee = (tp == 1) ? cnt : ((2 * cnt > 255) ? 255 : 2 * cnt);
            m_slot[tf][tp] = 16'h0;
        end else begin
            efee = 0;
        end
        m_fee = efee;
        chk("load_moving", 32'(moving), 32'(plate));
        chk("load_fee", 32'(fee), 32'(m_fee));
        chk("load_slot", parked[tf], {m_slot[tf][0], m_slot[tf][1]});
        chk("load_state", 32'(curr_state_for_test), 32'd3);
        first = 1'b1;
        while (m_floor != dst) begin
            if (poke && first) begin
                in_mode       = 1'b1;
                license_plate = 16'h5557;
            end
            tick();
            in_mode = 1'b0;
            first   = 1'b0;
            m_floor += (dst > m_floor) ? 1 : -1;
            chk("carry_floor", 32'(current_floor), 32'(m_floor));
            chk("carry_moving", 32'(moving), 32'(plate));
        end
        tick();
        if (entry) begin
            m_slot[tf][tp] = plate;
            m_park[tf][tp] = edge_n;
        end
        chk("drop_state", 32'(curr_state_for_test), 32'd0);
        chk("drop_plate_internal", 32'(license_plate_internal), 32'(plate));
        chk_all("drop");
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] pl;
        int          r;

        reset         = 1'b0;
        license_plate = 16'h0;
        in_mode       = 1'b0;
        out_mode      = 1'b0;
        leakage       = 1'b0;
        leakage_floor = 3'd0;
        model_reset();
        idle(3);
        chk("rst_state", 32'(curr_state_for_test), 32'd0);
        chk("rst_plate_internal", 32'(license_plate_internal), 32'd0);
        chk("rst_in_internal", 32'(in_mode_internal), 32'd0);
        chk_all("reset");
        reset = 1'b1;
        idle(2);

        do_request(1'b1, 16'h9423, 1'b0);
        chk("suv_type", 32'(plate_type), 32'd1);
        do_request(1'b1, 16'h8754, 1'b0);
        leak(1);
        leak(0);
        do_request(1'b1, 16'h1235, 1'b0);
        idle(17);
        do_request(1'b0, 16'h8754, 1'b0);
        do_request(1'b0, 16'h1111, 1'b0);
        do_request(1'b1, 16'h9423, 1'b0);
        do_request(1'b1, 16'h2468, 1'b1);
        idle(300);
        do_request(1'b0, 16'h2468, 1'b0);
        do_request(1'b0, 16'h1235, 1'b0);

        // Abort an entry mid-flight with an asynchronous reset.
        license_plate = 16'h7777;
        in_mode       = 1'b1;
        tick();
        in_mode = 1'b0;
        idle(2);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("abort_state", 32'(curr_state_for_test), 32'd0);
        chk_all("abort");
        tick();
        reset = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) do_request(1'b1, 16'h1001 + 16'(2 * i), 1'b0);
        chk("full_suv_after_fill", 32'(full_suv), 32'd1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                do_request(1'b1, rand_plate($urandom_range(0, 1) == 1), 1'b0);
            end else if (r < 8) begin
                q.delete();
                for (int f = 1; f <= 7; f++)
                    for (int p = 0; p < 2; p++)
                        if (m_slot[f][p] != 16'h0) q.push_back(m_slot[f][p]);
                if (q.size() > 0 && r != 7) pl = q[$urandom_range(0, q.size() - 1)];
                else pl = rand_plate($urandom_range(0, 1) == 1);
                do_request(1'b0, pl, 1'b0);
            end else if (r == 8) begin
                leak($urandom_range(0, 7));
            end else begin
                do_request(1'b1, rand_plate(1'b0), 1'b1);
            end
            idle($urandom_range(0, 6));
        end
        chk_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
